// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU op codes and sequencer FSM state encodings.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_AND, OP_OR, OP_XOR, OP_ADDS, OP_ADDU, OP_SUBS, OP_SUBU, OP_SHRL,
        OP_SHLL, OP_SHRA, OP_SLT, OP_SLTU, OP_MULU, OP_DIVU, OP_REMU, OP_PASS
    } op_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/alu_seq_md.sv
// alu_md_iter: WIDTH-step shift-add multiply / restoring divide with a done pulse.
module alu_md_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    // x: product / remainder, y: shifted multiplicand / dividend->quotient, z: multiplier / divisor
    logic [WIDTH-1:0] x, y, z, cx, cy, cz, nx, ny, nz;
    logic [WIDTH:0]   sh, diff;
    logic [CW-1:0]    cnt;
    logic             busy, mul, rem, mul_c;

    // The first step runs on the start edge itself, so WIDTH steps end WIDTH-1 edges later.
    always_comb begin
        mul_c = start ? (op == OP_MULU) : mul;
        cx    = start ? '0 : x;
        cy    = start ? a : y;
        cz    = start ? b : z;
        sh    = {cx, cy[WIDTH-1]};
        diff  = sh - {1'b0, cz};
        nx    = mul_c ? (cz[0] ? cx + cy : cx) : (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]);
        ny    = mul_c ? cy << 1 : {cy[WIDTH-2:0], ~diff[WIDTH]};
        nz    = mul_c ? cz >> 1 : cz;
    end

    assign done   = busy && cnt == CW'(WIDTH);
    assign result = (mul || rem) ? x : y;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            mul  <= 1'b0;
            rem  <= 1'b0;
        end else begin
            if (start) begin
                mul <= op == OP_MULU;
                rem <= op == OP_REMU;
            end
            if (start || (busy && !done)) begin
                x   <= nx;
                y   <= ny;
                z   <= nz;
                cnt <= start ? CW'(1) : cnt + CW'(1);
            end
            busy <= start || (busy && !done);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with single-cycle logic ops and iterative multiply/divide.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             of,
    output logic             dz
);

    state_t           state, state_n;
    op_t              opc;
    logic             accept, long_op, md_done, a_of, a_dz, of_r, dz_r;
    logic [WIDTH-1:0] a_res, md_res, sum, dif;

    assign opc       = op_t'(op);
    assign long_op   = opc == OP_MULU || ((opc == OP_DIVU || opc == OP_REMU) && in_1 != '0);
    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign of        = of_r && out_valid;
    assign dz        = dz_r && out_valid;

    always_comb begin
        state_n = accept ? (long_op ? CALC : DONE)
                : state == CALC ? (md_done ? DONE : CALC)
                : (state == DONE && !out_ready) ? DONE : IDLE;
    end

    // Divide by zero never reaches the iterator; its fixed result is produced here.
    always_comb begin
        sum   = in_0 + in_1;
        dif   = in_0 - in_1;
        a_res = in_0;
        a_of  = 1'b0;
        a_dz  = 1'b0;
        case (opc)
            OP_AND:  a_res = in_0 & in_1;
            OP_OR:   a_res = in_0 | in_1;
            OP_XOR:  a_res = in_0 ^ in_1;
            OP_ADDS: begin
                a_res = sum;
                a_of  = in_0[WIDTH-1] == in_1[WIDTH-1] && sum[WIDTH-1] != in_0[WIDTH-1];
            end
            OP_ADDU: a_res = sum;
            OP_SUBS: begin
                a_res = dif;
                a_of  = in_0[WIDTH-1] != in_1[WIDTH-1] && dif[WIDTH-1] != in_0[WIDTH-1];
            end
            OP_SUBU: a_res = dif;
            OP_SHRL: a_res = in_0 >> in_1[SHW-1:0];
            OP_SHLL: a_res = in_0 << in_1[SHW-1:0];
            OP_SHRA: a_res = $signed(in_0) >>> in_1[SHW-1:0];
            OP_SLT:  a_res = {{(WIDTH-1){1'b0}}, $signed(in_0) < $signed(in_1)};
            OP_SLTU: a_res = {{(WIDTH-1){1'b0}}, in_0 < in_1};
            OP_DIVU: begin
                a_res = '1;
                a_dz  = in_1 == '0;
            end
            OP_REMU: a_dz = in_1 == '0;
            default: a_res = in_0;
        endcase
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .reset_ (reset_),
        .start  (accept && long_op),
        .op     (opc),
        .a      (in_0),
        .b      (in_1),
        .done   (md_done),
        .result (md_res)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            out   <= '0;
            of_r  <= 1'b0;
            dz_r  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept && !long_op) begin
                out  <= a_res;
                of_r <= a_of;
                dz_r <= a_dz;
            end else if (md_done) begin
                out  <= md_res;
                of_r <= 1'b0;
                dz_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH = 32.
module tb_alu_seq;

    typedef struct {
        logic [31:0] out;
        logic        of;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct packed {
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    logic        clk, reset_, in_valid, in_ready, out_valid, out_ready, of, dz;
    logic [3:0]  op;
    logic [31:0] in_0, in_1, out;
    logic [31:0] h_out;
    logic        h_of, h_dz, seen;
    exp_t        sb[$];
    int          total, bad, cyc, w, vcnt;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_0      (in_0),
        .in_1      (in_1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .of        (of),
        .dz        (dz)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: wide signed arithmetic for overflow, native operators for mul/div.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint s;
        e.out = 0; e.of = 0; e.dz = 0; e.lat = 1; e.acc = 0;
        case (o)
            0:  e.out = a & b;
            1:  e.out = a | b;
            2:  e.out = a ^ b;
            3:  begin
                e.out = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                e.of = s != longint'($signed(e.out));
            end
            4:  e.out = a + b;
            5:  begin
                e.out = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.of = s != longint'($signed(e.out));
            end
            6:  e.out = a - b;
            7:  e.out = a >> b[4:0];
            8:  e.out = a << b[4:0];
            9:  e.out = $signed(a) >>> b[4:0];
            10: e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            11: e.out = (a < b) ? 32'd1 : 32'd0;
            12: begin e.out = a * b; e.lat = 33; end
            13: if (b == 0) begin e.out = 32'hFFFFFFFF; e.dz = 1; end
                else begin e.out = a / b; e.lat = 33; end
            14: if (b == 0) begin e.out = a; e.dz = 1; end
                else begin e.out = a % b; e.lat = 33; end
            default: e.out = a;
        endcase
        return e;
    endfunction

    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int waited);
        exp_t e;
        in_valid = 1; op = o; in_0 = a; in_1 = b; waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        e = model(o, a, b);
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 0;
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", sb.size(), 0);
    endtask

    // Output monitor: latency on first sight, stability while stalled, value on handshake.
    always @(negedge clk) begin
        if (reset_ && out_valid) begin
            if (sb.size() == 0) check("spurious_valid", out_valid, 0);
            else begin
                if (!seen) begin
                    check("latency", cyc - sb[0].acc + 1, sb[0].lat);
                    seen = 1; h_out = out; h_of = of; h_dz = dz;
                end else check("stable", {out, of, dz}, {h_out, h_of, h_dz});
                check("ready_in_done", in_ready, out_ready);
                if (out_ready) begin
                    check("out", out, sb[0].out);
                    check("of", of, sb[0].of);
                    check("dz", dz, sb[0].dz);
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end else if (reset_ && sb.size() != 0) begin
            check("calc_ready", in_ready, 0);
            check("calc_flags", {of, dz}, 0);
        end
    end

    vec_t vecs [22] = '{
        {4'd3,  32'h7FFFFFFF, 32'h00000001},
        {4'd5,  32'h00000000, 32'h80000000},
        {4'd3,  32'h00000000, 32'h80000000},
        {4'd9,  32'h80000000, 32'h00000024},
        {4'd10, 32'hFFFFFFFF, 32'h00000001},
        {4'd11, 32'hFFFFFFFF, 32'h00000001},
        {4'd12, 32'h00010000, 32'h00010001},
        {4'd13, 32'd100,      32'd7},
        {4'd14, 32'd100,      32'd7},
        {4'd13, 32'd5,        32'd0},
        {4'd14, 32'd5,        32'd0},
        {4'd0,  32'hF0F0FF00, 32'h0FF0F0F0},
        {4'd1,  32'hF0F0FF00, 32'h0FF0F0F0},
        {4'd2,  32'hF0F0FF00, 32'h0FF0F0F0},
        {4'd4,  32'hFFFFFFFF, 32'h00000002},
        {4'd6,  32'h00000001, 32'h00000002},
        {4'd7,  32'h80000000, 32'h0000003F},
        {4'd8,  32'h00000001, 32'h0000001F},
        {4'd15, 32'hDEADBEEF, 32'h00000000},
        {4'd13, 32'hFFFFFFFF, 32'h00000010},
        {4'd12, 32'hDEADBEEF, 32'h12345678},
        {4'd14, 32'hDEADBEEF, 32'h00012345}
    };

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cyc = 0; seen = 0; vcnt = 0;
        reset_ = 0; in_valid = 0; op = 0; in_0 = 0; in_1 = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_flags", {of, dz}, 0);
        @(posedge clk);
        #1 reset_ = 1;
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        foreach (vecs[i]) send(vecs[i].o, vecs[i].a, vecs[i].b, w);
        for (int i = 0; i < 10; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            send(ro, ra, rb, w);
        end
        drain;
        // Stall in DONE, then retire and accept in the same cycle.
        out_ready = 0;
        send(4'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, w);
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
        send(4'd12, 32'h00000003, 32'h00000007, w);
        check("b2b_wait", w, 0);
        drain;
        // Abort a multiply mid-iteration with reset.
        send(4'd12, 32'h00000003, 32'h00000005, w);
        repeat (10) @(posedge clk);
        #1 reset_ = 0;
        sb.delete();
        seen = 0;
        repeat (2) @(posedge clk);
        #1 reset_ = 1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("abort_valid", vcnt, 0);
        check("abort_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(4'd4, 32'h00000001, 32'h00000002, w);
        drain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
